// File: rtl/pgs_pkg.sv
// Shared types, widths and helpers for the port-group sequencer.
// The pipe entry layout is fixed here, so instances must use these default widths.
package pgs_pkg;

  localparam int unsigned PGS_VRF_ADDR_W = 9;
  localparam int unsigned PGS_VL_W       = 12;
  localparam int unsigned PGS_LANES      = 8;

  typedef enum logic [1:0] {
    PGS_IDLE  = 2'd0,
    PGS_READ  = 2'd1,
    PGS_DRAIN = 2'd2
  } pgs_state_e;

  typedef struct packed {
    logic                      valid;
    logic [PGS_VRF_ADDR_W-1:0] addr;
    logic [PGS_LANES-1:0]      mask;
  } pgs_pipe_t;

  // Element mask for the final beat: only the lower (vl mod lanes) bits when vl is ragged.
  function automatic logic [PGS_LANES-1:0] last_mask(input logic [PGS_VL_W-1:0] vl,
                                                     input int unsigned         lanes);
    logic [PGS_LANES-1:0] mask;
    int unsigned          rem;
    rem  = 32'(vl) & (lanes - 1);
    mask = '1;
    if (rem != 0) begin
      mask = ~(mask << rem);
    end
    return mask;
  endfunction

endpackage

// File: rtl/port_group_sequencer_if.sv
// Allocation handshake plus VRF read/write beat signals for one write port group.
// The sequencer sits on the slave modport; the allocator/VRF side uses master.
interface port_group_sequencer_if
  import pgs_pkg::*;
#(
  parameter int unsigned VRF_ADDR_W = PGS_VRF_ADDR_W,
  parameter int unsigned VL_W       = PGS_VL_W,
  parameter int unsigned LANES      = PGS_LANES
);

  logic                  start_i;
  logic [VL_W-1:0]       vl_i;
  logic [VRF_ADDR_W-1:0] vs1_addr_i;
  logic [VRF_ADDR_W-1:0] vs2_addr_i;
  logic [VRF_ADDR_W-1:0] vs3_addr_i;
  logic                  op3_en_i;
  logic [VRF_ADDR_W-1:0] vd_addr_i;
  logic                  rd_stall_i;

  logic                  rd_en_o;
  logic                  rd_op3_en_o;
  logic [VRF_ADDR_W-1:0] rd_addr1_o;
  logic [VRF_ADDR_W-1:0] rd_addr2_o;
  logic [VRF_ADDR_W-1:0] rd_addr3_o;
  logic                  wr_en_o;
  logic [VRF_ADDR_W-1:0] wr_addr_o;
  logic [LANES-1:0]      wr_mask_o;
  logic                  port_rdy_o;
  logic                  busy_o;

  modport slave (
    input  start_i, vl_i, vs1_addr_i, vs2_addr_i, vs3_addr_i, op3_en_i, vd_addr_i,
           rd_stall_i,
    output rd_en_o, rd_op3_en_o, rd_addr1_o, rd_addr2_o, rd_addr3_o, wr_en_o, wr_addr_o,
           wr_mask_o, port_rdy_o, busy_o
  );

  modport master (
    output start_i, vl_i, vs1_addr_i, vs2_addr_i, vs3_addr_i, op3_en_i, vd_addr_i,
           rd_stall_i,
    input  rd_en_o, rd_op3_en_o, rd_addr1_o, rd_addr2_o, rd_addr3_o, wr_en_o, wr_addr_o,
           wr_mask_o, port_rdy_o, busy_o
  );

endinterface

// File: rtl/pgs_delay_pipe.sv
// Fixed-latency shift register carrying write beats from read issue to VRF write.
// Never stalls; bubbles travel as invalid entries.
module pgs_delay_pipe
  import pgs_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  pgs_pipe_t i_push,
  output pgs_pipe_t o_tail,
  output logic      o_inflight
);

  pgs_pipe_t r_stage [PIPE_LAT];
  logic      w_inflight;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_push;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // The tail stage is excluded: it may be writing in the same cycle the group goes idle.
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
      w_inflight = w_inflight | r_stage[i].valid;
    end
  end

  assign o_tail     = r_stage[PIPE_LAT-1];
  assign o_inflight = w_inflight;

endmodule

// File: rtl/port_group_sequencer.sv
// Responder for one write port group: latches an allocated instruction, issues read beats,
// and replays each beat as a VRF write PIPE_LAT cycles later before re-arming.
module port_group_sequencer
  import pgs_pkg::*;
#(
  parameter int unsigned VRF_ADDR_W = PGS_VRF_ADDR_W,
  parameter int unsigned VL_W       = PGS_VL_W,
  parameter int unsigned LANES      = PGS_LANES,
  parameter int unsigned PIPE_LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  port_group_sequencer_if.slave  bus
);

  localparam int unsigned LOG2_LANES = $clog2(LANES);

  localparam logic [1:0] S_IDLE  = PGS_IDLE;
  localparam logic [1:0] S_READ  = PGS_READ;
  localparam logic [1:0] S_DRAIN = PGS_DRAIN;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [VL_W-1:0]       r_vl;
  logic [VL_W:0]         r_beats;
  logic [VL_W:0]         r_beat_cnt;
  logic [VRF_ADDR_W-1:0] r_vs1;
  logic [VRF_ADDR_W-1:0] r_vs2;
  logic [VRF_ADDR_W-1:0] r_vs3;
  logic [VRF_ADDR_W-1:0] r_vd;
  logic                  r_op3_en;
  logic                  r_port_rdy;

  logic                  w_start;
  logic                  w_issue;
  logic                  w_last_beat;
  logic [VL_W:0]         w_vl_ext;
  logic [VL_W:0]         w_beats;
  logic [VRF_ADDR_W-1:0] w_beat_off;
  pgs_pipe_t             w_push;
  pgs_pipe_t             w_tail;
  logic                  w_inflight;

  // Only an idle group accepts an allocation; that also covers the re-arm cycle.
  assign w_start     = (r_state == S_IDLE) && bus.start_i;
  assign w_issue     = (r_state == S_READ) && !bus.rd_stall_i;
  assign w_last_beat = (r_beat_cnt == r_beats - (VL_W+1)'(1));
  assign w_beat_off  = VRF_ADDR_W'(r_beat_cnt);

  // One extra bit so vl near 2^VL_W cannot overflow the round-up.
  assign w_vl_ext = {1'b0, bus.vl_i};
  assign w_beats  = (w_vl_ext + (VL_W+1)'(LANES - 1)) >> LOG2_LANES;

  always_comb begin
    w_push = '0;
    if (w_issue) begin
      w_push.valid = 1'b1;
      w_push.addr  = r_vd + w_beat_off;
      w_push.mask  = w_last_beat ? last_mask(r_vl, LANES) : '1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = (bus.vl_i == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (w_issue && w_last_beat) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_inflight) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_port_rdy <= 1'b1;
      r_vl       <= '0;
      r_beats    <= '0;
      r_beat_cnt <= '0;
      r_vs1      <= '0;
      r_vs2      <= '0;
      r_vs3      <= '0;
      r_vd       <= '0;
      r_op3_en   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_port_rdy <= (w_state_next == S_IDLE);
      if (w_start) begin
        r_vl       <= bus.vl_i;
        r_beats    <= w_beats;
        r_beat_cnt <= '0;
        r_vs1      <= bus.vs1_addr_i;
        r_vs2      <= bus.vs2_addr_i;
        r_vs3      <= bus.vs3_addr_i;
        r_vd       <= bus.vd_addr_i;
        r_op3_en   <= bus.op3_en_i;
      end else if (w_issue) begin
        r_beat_cnt <= r_beat_cnt + (VL_W+1)'(1);
      end
    end
  end

  pgs_delay_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_delay_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .o_tail     (w_tail),
    .o_inflight (w_inflight)
  );

  assign bus.rd_en_o     = w_issue;
  assign bus.rd_op3_en_o = w_issue && r_op3_en;
  assign bus.rd_addr1_o  = r_vs1 + w_beat_off;
  assign bus.rd_addr2_o  = r_vs2 + w_beat_off;
  assign bus.rd_addr3_o  = r_vs3 + w_beat_off;
  assign bus.wr_en_o     = w_tail.valid;
  assign bus.wr_addr_o   = w_tail.addr;
  assign bus.wr_mask_o   = w_tail.valid ? w_tail.mask : '0;
  assign bus.port_rdy_o  = r_port_rdy;
  assign bus.busy_o      = !r_port_rdy;

endmodule

// File: tb/tb_port_group_sequencer.sv
// Directed bench for port_group_sequencer: per-cycle handshake checks against
// hand-computed enable/ready patterns plus captured address and mask checks.
module tb_port_group_sequencer;
  import pgs_pkg::*;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  logic [31:0] cap_rd1 [16];
  logic [31:0] cap_rd2 [16];
  logic [31:0] cap_rd3 [16];
  logic [31:0] cap_op3 [16];
  logic [31:0] cap_wa  [16];
  logic [31:0] cap_wm  [16];

  port_group_sequencer_if bus ();

  port_group_sequencer #(
    .PIPE_LAT (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge; inputs driven here apply at the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0: present start_i with the instruction fields.
  task automatic begin_op(input string name, input logic [11:0] vl, input logic [8:0] vs1,
                          input logic [8:0] vs2, input logic [8:0] vs3, input logic op3,
                          input logic [8:0] vd);
    cyc();
    bus.start_i    = 1'b1;
    bus.vl_i       = vl;
    bus.vs1_addr_i = vs1;
    bus.vs2_addr_i = vs2;
    bus.vs3_addr_i = vs3;
    bus.op3_en_i   = op3;
    bus.vd_addr_i  = vd;
    #3;
    chk($sformatf("%s port_rdy c0", name), 32'(bus.port_rdy_o), 32'd1);
  endtask

  // Cycles 1..n: drive stall/extra-start/reset per bit and check rd_en, wr_en, port_rdy, busy.
  task automatic run(input string name, input int n, input logic [15:0] stall,
                     input logic [15:0] st2, input logic [15:0] rst, input logic [15:0] exp_rd,
                     input logic [15:0] exp_wr, input logic [15:0] exp_rdy);
    for (int c = 1; c <= n; c++) begin
      cyc();
      bus.start_i    = st2[c];
      bus.rd_stall_i = stall[c];
      rstn           = !rst[c];
      if (st2[c]) begin
        bus.vl_i       = 12'd3;
        bus.vs1_addr_i = 9'h1AB;
        bus.vd_addr_i  = 9'h1CD;
      end
      #3;
      chk($sformatf("%s rd_en c%0d", name, c), 32'(bus.rd_en_o), 32'(exp_rd[c]));
      chk($sformatf("%s wr_en c%0d", name, c), 32'(bus.wr_en_o), 32'(exp_wr[c]));
      chk($sformatf("%s port_rdy c%0d", name, c), 32'(bus.port_rdy_o), 32'(exp_rdy[c]));
      chk($sformatf("%s busy c%0d", name, c), 32'(bus.busy_o), 32'(!exp_rdy[c]));
      cap_rd1[c] = 32'(bus.rd_addr1_o);
      cap_rd2[c] = 32'(bus.rd_addr2_o);
      cap_rd3[c] = 32'(bus.rd_addr3_o);
      cap_op3[c] = 32'(bus.rd_op3_en_o);
      cap_wa[c]  = 32'(bus.wr_addr_o);
      cap_wm[c]  = 32'(bus.wr_mask_o);
    end
    bus.start_i    = 1'b0;
    bus.rd_stall_i = 1'b0;
    rstn           = 1'b1;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rstn           = 1'b0;
    bus.start_i    = 1'b0;
    bus.vl_i       = '0;
    bus.vs1_addr_i = '0;
    bus.vs2_addr_i = '0;
    bus.vs3_addr_i = '0;
    bus.op3_en_i   = 1'b0;
    bus.vd_addr_i  = '0;
    bus.rd_stall_i = 1'b0;

    // Reset state
    cyc();
    cyc();
    rstn = 1'b1;
    #3;
    chk("rst port_rdy", 32'(bus.port_rdy_o), 32'd1);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst rd_en", 32'(bus.rd_en_o), 32'd0);
    chk("rst op3_en", 32'(bus.rd_op3_en_o), 32'd0);
    chk("rst wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("rst wr_mask", 32'(bus.wr_mask_o), 32'd0);
    chk("rst wr_addr", 32'(bus.wr_addr_o), 32'd0);
    chk("rst rd_addr1", 32'(bus.rd_addr1_o), 32'd0);

    // vl=16: reads c1-2, writes c5-6, ready again c7
    begin_op("t1", 12'd16, 9'h010, 9'h020, 9'h030, 1'b0, 9'h100);
    run("t1", 8, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 16'h0060, 16'h0180);
    chk("t1 rd_addr1 c1", cap_rd1[1], 32'h010);
    chk("t1 rd_addr1 c2", cap_rd1[2], 32'h011);
    chk("t1 rd_addr2 c2", cap_rd2[2], 32'h021);
    chk("t1 rd_addr3 c2", cap_rd3[2], 32'h031);
    chk("t1 op3 c1", cap_op3[1], 32'd0);
    chk("t1 wr_mask c4", cap_wm[4], 32'h00);
    chk("t1 wr_addr c5", cap_wa[5], 32'h100);
    chk("t1 wr_mask c5", cap_wm[5], 32'hFF);
    chk("t1 wr_addr c6", cap_wa[6], 32'h101);
    chk("t1 wr_mask c6", cap_wm[6], 32'hFF);

    // vl=13: ragged final beat; start_i on the re-arm cycle (c6) is ignored
    begin_op("t2", 12'd13, 9'h000, 9'h000, 9'h000, 1'b0, 9'h040);
    run("t2", 8, 16'h0000, 16'h0040, 16'h0000, 16'h0006, 16'h0060, 16'h0180);
    chk("t2 wr_addr c5", cap_wa[5], 32'h040);
    chk("t2 wr_mask c5", cap_wm[5], 32'hFF);
    chk("t2 wr_addr c6", cap_wa[6], 32'h041);
    chk("t2 wr_mask c6", cap_wm[6], 32'h1F);

    // vl=8 with stall in c1: read slips to c2, write c6, ready c7
    begin_op("t3", 12'd8, 9'h0A0, 9'h000, 9'h000, 1'b0, 9'h0C0);
    run("t3", 8, 16'h0002, 16'h0000, 16'h0000, 16'h0004, 16'h0040, 16'h0180);
    chk("t3 rd_addr1 c1", cap_rd1[1], 32'h0A0);
    chk("t3 rd_addr1 c2", cap_rd1[2], 32'h0A0);
    chk("t3 wr_addr c6", cap_wa[6], 32'h0C0);
    chk("t3 wr_mask c6", cap_wm[6], 32'hFF);

    // vl=0: busy for exactly one cycle, no traffic
    begin_op("t4", 12'd0, 9'h055, 9'h000, 9'h000, 1'b1, 9'h066);
    run("t4", 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h001C);
    chk("t4 op3 c1", cap_op3[1], 32'd0);

    // Address wrap and op3 port
    begin_op("t5", 12'd16, 9'h1FF, 9'h100, 9'h1FE, 1'b1, 9'h1FF);
    run("t5", 8, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 16'h0060, 16'h0180);
    chk("t5 rd_addr1 c1", cap_rd1[1], 32'h1FF);
    chk("t5 rd_addr1 c2", cap_rd1[2], 32'h000);
    chk("t5 rd_addr3 c2", cap_rd3[2], 32'h1FF);
    chk("t5 op3 c1", cap_op3[1], 32'd1);
    chk("t5 op3 c2", cap_op3[2], 32'd1);
    chk("t5 op3 c3", cap_op3[3], 32'd0);
    chk("t5 wr_addr c5", cap_wa[5], 32'h1FF);
    chk("t5 wr_addr c6", cap_wa[6], 32'h000);

    // Start ignored while busy (c2), reset in c3 aborts with no writes
    begin_op("t6", 12'd16, 9'h050, 9'h000, 9'h000, 1'b0, 9'h080);
    run("t6", 8, 16'h0000, 16'h0004, 16'h0008, 16'h0006, 16'h0000, 16'h01F0);
    chk("t6 rd_addr1 c2", cap_rd1[2], 32'h051);
    chk("t6 rd_addr1 c4", cap_rd1[4], 32'h000);
    chk("t6 wr_mask c5", cap_wm[5], 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
